packet_injector: RTL
====================

# packet_injector

Parametrised network-adapter injector that takes one message plus destination address per valid/ready handshake. It serialises the message into a wormhole packet of typed flits (single, or head/body/tail), each carrying the destination and one payload slice. It sits between the core-side message interface and the router local input port, and adds output backpressure plus optional credit-based flow control.

## Interface
Parameters:
- MSG_WIDTH, 64, message width in bits; must be an integer multiple of PAYLOAD_WIDTH.
- ADDR_WIDTH, 4, destination address width.
- PAYLOAD_WIDTH, 16, payload bits per flit.
- CREDITS, 4, router input buffer depth; used only with the credit feature.
- Derived: NUM_FLITS = MSG_WIDTH/PAYLOAD_WIDTH; FLIT_WIDTH = 2+ADDR_WIDTH+PAYLOAD_WIDTH.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- msg_valid, input, 1, message and dest valid.
- msg_ready, output, 1, injector can accept a message.
- message, input, MSG_WIDTH, message to send.
- dest, input, ADDR_WIDTH, destination address.
- flit_valid, output, 1, flit is valid.
- flit_ready, input, 1, router accepts the flit; present only without the credit feature.
- credit_in, input, 1, one-cycle credit-return pulse; present only with the credit feature.
- flit, output, FLIT_WIDTH, {type[1:0], dest, payload}.
- busy, output, 1, a packet is in progress.

## Operation
- Flit type encoding: SINGLE=2'b11, HEAD=2'b10, BODY=2'b00, TAIL=2'b01. If NUM_FLITS==1, the only flit is SINGLE. Otherwise the order is HEAD, BODY×(NUM_FLITS-2), TAIL.
- FSM states:
  - IDLE: busy=0, flit_valid=0.
  - SEND: busy=1.
- Transitions:
  - IDLE→SEND on msg_fire = msg_valid & msg_ready. message and dest are latched and the index counter is set to 0.
  - In SEND, each out_fire advances the index. On out_fire at index NUM_FLITS-1, the block returns to IDLE, unless msg_fire occurs in the same cycle. In that case it stays in SEND with the new message latched and the index set to 0.
- Payload slice order is LSB first: index i carries message[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]. dest is identical in every flit of a packet.
- msg_ready = IDLE | (SEND & index==NUM_FLITS-1 & out_fire). This is a combinational path from flit_ready (or credit availability).
- Without the credit feature:
  - out_fire = flit_valid & flit_ready.
  - flit_valid = SEND.
  - Once asserted, flit_valid and flit stay stable until out_fire.
- The index counter is $clog2(NUM_FLITS) bits wide, minimum 1. It never exceeds NUM_FLITS-1.
- Reset, including mid-packet: return to IDLE and drop the partial packet; no tail flit is emitted.
- Reset values: msg_ready=1, flit_valid=0, busy=0, flit=0, index=0.

## Timing
- Latency: the head flit is valid in the cycle after msg_fire. flit is driven from registered state and index only, not from message.
- Throughput: NUM_FLITS cycles per message with continuous ready, with no bubble between packets (back-to-back acceptance as above).
- Deasserting flit_ready stalls the packet at the current index. The flit is held and nothing is lost.

## Configuration
- Macro: PKT_INJ_CREDIT_EN.
- Defined:
  - The flit_ready port is absent and the credit_in port is present.
  - A credit counter of $clog2(CREDITS+1) bits resets to CREDITS.
  - flit_valid = SEND & (credits != 0).
  - out_fire = flit_valid, so every valid flit is sent.
  - credits decrement on out_fire and increment on credit_in.
  - credit_in and out_fire in the same cycle leave credits unchanged.
  - credit_in while credits==CREDITS is ignored (saturates).
- Undefined: pure valid/ready backpressure as described above; no counter.

## Structure
- Shared package noc_pkg holds:
  - the flit type constants (FLIT_SINGLE, FLIT_HEAD, FLIT_BODY, FLIT_TAIL);
  - the flit type typedef (2 bits);
  - a flit_width(addr, payload) function.
- The router uses the same package.
- One sub-module, credit_counter: saturating up/down counter with parameter MAX. It is instantiated only under PKT_INJ_CREDIT_EN.
- Elaboration check: MSG_WIDTH % PAYLOAD_WIDTH == 0.

## Test plan
- Defaults, flit_ready=1, message=64'h4444_3333_2222_1111, dest=4'h5 → in four consecutive cycles: flits {HEAD,5,1111}, {BODY,5,2222}, {BODY,5,3333}, {TAIL,5,4444}; msg_ready=1 in the TAIL cycle.
- Back-to-back: a second message is presented during the TAIL cycle → accepted in that cycle; its HEAD flit appears the next cycle with no gap.
- flit_ready toggles 1,0,0,1 mid-packet → flit held stable while ready is low; the sequence is complete with no duplicated or skipped flit.
- MSG_WIDTH=PAYLOAD_WIDTH=16 → one SINGLE flit per message; msg_ready is high every cycle under full throughput.
- rst pulse asynchronously after the HEAD flit → flit_valid=0 and busy=0 immediately; the next message starts again with HEAD.
- PKT_INJ_CREDIT_EN, CREDITS=2, no credit_in → exactly 2 flits sent, then flit_valid=0. A credit_in pulse → exactly one more flit. A simultaneous credit_in and send leaves the count unchanged.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, state encoding, and flit width helper.
// Used by the injector and by the router.
package noc_pkg;

    typedef logic [1:0] flit_type_t;

    localparam flit_type_t FLIT_SINGLE = 2'b11;
    localparam flit_type_t FLIT_HEAD   = 2'b10;
    localparam flit_type_t FLIT_BODY   = 2'b00;
    localparam flit_type_t FLIT_TAIL   = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } inj_state_t;

    function automatic int flit_width(input int addr, input int payload);
        return 2 + addr + payload;
    endfunction

endpackage

// File: rtl/packet_injector_if.sv
// Message-in / flit-out bundle for the packet injector; PKT_INJ_CREDIT_EN swaps
// flit_ready for credit_in. slave = injector side, master = core/router side.
interface packet_injector_if
    import noc_pkg::*;
#(
    parameter int MSG_WIDTH     = 64,
    parameter int ADDR_WIDTH    = 4,
    parameter int PAYLOAD_WIDTH = 16
);
    localparam int FLIT_WIDTH = flit_width(ADDR_WIDTH, PAYLOAD_WIDTH);

    logic                  msg_valid;
    logic                  msg_ready;
    logic [MSG_WIDTH-1:0]  message;
    logic [ADDR_WIDTH-1:0] dest;
    logic                  flit_valid;
    logic [FLIT_WIDTH-1:0] flit;
    logic                  busy;
`ifdef PKT_INJ_CREDIT_EN
    logic                  credit_in;

    modport slave  (input  msg_valid, message, dest, credit_in,
                    output msg_ready, flit_valid, flit, busy);
    modport master (output msg_valid, message, dest, credit_in,
                    input  msg_ready, flit_valid, flit, busy);
`else
    logic                  flit_ready;

    modport slave  (input  msg_valid, message, dest, flit_ready,
                    output msg_ready, flit_valid, flit, busy);
    modport master (output msg_valid, message, dest, flit_ready,
                    input  msg_ready, flit_valid, flit, busy);
`endif
endinterface

// File: rtl/packet_injector_credit_counter.sv
// Saturating up/down credit counter, reset to MAX; inc+dec together hold the count.
// Increments at MAX and decrements at zero are ignored.
module credit_counter #(
    parameter  int MAX = 4,
    localparam int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CW'(MAX);
        end else if (inc && !dec && count != CW'(MAX)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/packet_injector.sv
// Serialises one message per handshake into HEAD/BODY/TAIL (or SINGLE) flits, LSB slice first.
// Flit valid the cycle after acceptance; stalls on flit_ready, or on zero credits with PKT_INJ_CREDIT_EN.
module packet_injector
    import noc_pkg::*;
#(
    parameter int MSG_WIDTH     = 64,
    parameter int ADDR_WIDTH    = 4,
    parameter int PAYLOAD_WIDTH = 16,
    parameter int CREDITS       = 4
) (
    input logic               clk,
    input logic               rst,
    packet_injector_if.slave  bus
);
    localparam int NUM_FLITS  = MSG_WIDTH / PAYLOAD_WIDTH;
    localparam int FLIT_WIDTH = flit_width(ADDR_WIDTH, PAYLOAD_WIDTH);
    localparam int IDX_W      = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FLITS - 1);

    if (MSG_WIDTH % PAYLOAD_WIDTH != 0) begin : g_width_chk
        $error("MSG_WIDTH must be a multiple of PAYLOAD_WIDTH");
    end
    if (CREDITS < 1) begin : g_credit_chk
        $error("CREDITS must be at least 1");
    end

    inj_state_t                            state, state_nxt;
    logic [NUM_FLITS-1:0][PAYLOAD_WIDTH-1:0] msg_q;
    logic [ADDR_WIDTH-1:0]                 dest_q;
    logic [IDX_W-1:0]                      idx;
    logic [PAYLOAD_WIDTH-1:0]              payload;
    logic                                  last, has_credit, out_fire, msg_fire, msg_ready;
    logic                                  flit_valid, busy;
    logic [FLIT_WIDTH-1:0]                 flit;

    function automatic flit_type_t type_at(input logic [IDX_W-1:0] i);
        if (NUM_FLITS == 1) return FLIT_SINGLE;
        if (i == '0)        return FLIT_HEAD;
        if (i == LAST)      return FLIT_TAIL;
        return FLIT_BODY;
    endfunction

    if (NUM_FLITS == 1) begin : g_one
        assign payload = msg_q[0];
    end else begin : g_many
        assign payload = msg_q[idx];
    end

`ifdef PKT_INJ_CREDIT_EN
    localparam int CW = $clog2(CREDITS + 1);
    logic [CW-1:0] credits;

    credit_counter #(.MAX(CREDITS)) u_credits (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.credit_in),
        .dec   (out_fire),
        .count (credits)
    );
    assign has_credit = (credits != '0);
    // Without a ready, a valid flit with credit is always taken by the router.
    assign out_fire   = flit_valid;
`else
    assign has_credit = 1'b1;
    assign out_fire   = flit_valid & bus.flit_ready;
`endif

    assign last      = (idx == LAST);
    assign msg_ready = (state == ST_IDLE) | ((state == ST_SEND) & last & out_fire);
    assign msg_fire  = bus.msg_valid & msg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (msg_fire) state_nxt = ST_SEND;
            ST_SEND: if (out_fire && last && !msg_fire) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        flit_valid = 1'b0;
        busy       = 1'b0;
        flit       = '0;
        if (state == ST_SEND) begin
            busy       = 1'b1;
            flit_valid = has_credit;
            flit       = {type_at(idx), dest_q, payload};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q  <= '0;
            dest_q <= '0;
            idx    <= '0;
        end else if (msg_fire) begin
            msg_q  <= bus.message;
            dest_q <= bus.dest;
            idx    <= '0;
        end else if (out_fire) begin
            idx    <= last ? '0 : idx + 1'b1;
        end
    end

    assign bus.msg_ready  = msg_ready;
    assign bus.flit_valid = flit_valid;
    assign bus.flit       = flit;
    assign bus.busy       = busy;
endmodule
